// File: rtl/writeback_commit_arbiter_if.sv
// Writeback commit bus between the execution units and the commit arbiter.
//   unit_valid/unit_addr/unit_data : per-unit result offers (unit i in slice i)
//   unit_ready                     : per-unit accept, a transfer happens on valid & ready
//   write_addr/new_data/commit     : registered write port towards the register bank
// Modports:
//   slave  - the arbiter's view (consumes unit results, drives the write port)
//   master - the environment's view (execution units plus register bank)
interface writeback_commit_arbiter_if #(
  parameter int NUM_UNITS   = 4,
  parameter int PHYS_ADDR_W = 6,
  parameter int DATA_W      = 32
);
  logic [NUM_UNITS-1:0]                  unit_valid;
  logic [NUM_UNITS-1:0][PHYS_ADDR_W-1:0] unit_addr;
  logic [NUM_UNITS-1:0][DATA_W-1:0]      unit_data;
  logic [NUM_UNITS-1:0]                  unit_ready;
  logic [PHYS_ADDR_W-1:0]                write_addr;
  logic [DATA_W-1:0]                     new_data;
  logic                                  commit;

  modport slave (
    input  unit_valid, unit_addr, unit_data,
    output unit_ready, write_addr, new_data, commit
  );

  modport master (
    output unit_valid, unit_addr, unit_data,
    input  unit_ready, write_addr, new_data, commit
  );
endinterface

// File: rtl/writeback_commit_arbiter.sv
// Writeback commit arbiter: collects results from NUM_UNITS execution units into
// one-entry holding buffers, picks one full buffer per cycle round-robin and
// drives a registered commit towards the register bank write port. Results
// addressed to physical register 0 are accepted and drained but never committed.
// Ports:
//   clk          : clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset
//   bus          : writeback_commit_arbiter_if.slave (unit handshakes + write port)
//   stall_cycles : saturating count of cycles in which a full buffer lost
//                  arbitration; present only when WB_STALL_CNT_EN is defined
// Optional feature macro: WB_STALL_CNT_EN

// One holding slot per execution unit. Ready does not depend on in_valid, so
// a unit can present a new result in the same cycle its old one is drained.
module wb_unit_buf #(
  parameter int PHYS_ADDR_W = 6,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [PHYS_ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   grant,
  output logic                   ready,
  output logic                   full,
  output logic [PHYS_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]      data
);
  logic load;

  assign ready = ~full | grant;
  assign load  = in_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      // a reload in the draining cycle keeps the slot full
      full <= load | (full & ~grant);
      if (load) begin
        addr <= in_addr;
        data <= in_data;
      end
    end
  end
endmodule

module writeback_commit_arbiter #(
  parameter int NUM_UNITS   = 4,
  parameter int PHYS_ADDR_W = 6,
  parameter int DATA_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  writeback_commit_arbiter_if.slave         bus
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_cycles
`endif
);
  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_UNITS-1:0]                  unit_valid;
  logic [NUM_UNITS-1:0][PHYS_ADDR_W-1:0] unit_addr;
  logic [NUM_UNITS-1:0][DATA_W-1:0]      unit_data;
  logic [NUM_UNITS-1:0]                  unit_ready;

  logic [NUM_UNITS-1:0]                  buf_full;
  logic [NUM_UNITS-1:0][PHYS_ADDR_W-1:0] buf_addr;
  logic [NUM_UNITS-1:0][DATA_W-1:0]      buf_data;

  logic [NUM_UNITS-1:0]                  grant;
  logic                                  grant_any;
  logic [IDX_W-1:0]                      win;
  logic [IDX_W-1:0]                      rr_ptr;
  logic [IDX_W-1:0]                      rr_nxt;
  logic [PHYS_ADDR_W-1:0]                gnt_addr;
  logic [DATA_W-1:0]                     gnt_data;

  logic [PHYS_ADDR_W-1:0]                write_addr_q;
  logic [DATA_W-1:0]                     new_data_q;
  logic                                  commit_q;

  assign unit_valid     = bus.unit_valid;
  assign unit_addr      = bus.unit_addr;
  assign unit_data      = bus.unit_data;
  assign bus.unit_ready = unit_ready;
  assign bus.write_addr = write_addr_q;
  assign bus.new_data   = new_data_q;
  assign bus.commit     = commit_q;

  wb_unit_buf #(
    .PHYS_ADDR_W (PHYS_ADDR_W),
    .DATA_W      (DATA_W)
  ) u_buf [NUM_UNITS-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (unit_valid),
    .in_addr  (unit_addr),
    .in_data  (unit_data),
    .grant    (grant),
    .ready    (unit_ready),
    .full     (buf_full),
    .addr     (buf_addr),
    .data     (buf_data)
  );

  // Round-robin pick: scan upward from rr_ptr, wrapping, first full buffer wins.
  always_comb begin
    logic [IDX_W:0] sum;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_any = 1'b0;
    win       = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_UNITS))
        sum = sum - (IDX_W+1)'(NUM_UNITS);
      idx = sum[IDX_W-1:0];
      if (!grant_any && buf_full[idx]) begin
        grant_any = 1'b1;
        win       = idx;
      end
    end
    if (grant_any)
      grant[win] = 1'b1;
  end

  assign rr_nxt   = (win == IDX_W'(NUM_UNITS-1)) ? '0 : win + IDX_W'(1);
  assign gnt_addr = buf_addr[win];
  assign gnt_data = buf_data[win];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      commit_q     <= 1'b0;
      write_addr_q <= '0;
      new_data_q   <= '0;
    end else begin
      // address 0 drains like any result but never reaches the bank
      commit_q <= grant_any & (gnt_addr != '0);
      if (grant_any) begin
        rr_ptr       <= rr_nxt;
        write_addr_q <= gnt_addr;
        new_data_q   <= gnt_data;
      end
    end
  end

`ifdef WB_STALL_CNT_EN
  logic contention;

  // a full buffer that was not picked this cycle is a lost writeback slot
  assign contention = |(buf_full & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (contention && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_writeback_commit_arbiter.sv
module tb_writeback_commit_arbiter;
  localparam int NU = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk;
  logic rst_n;

  writeback_commit_arbiter_if #(.NUM_UNITS(NU), .PHYS_ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef WB_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  writeback_commit_arbiter #(.NUM_UNITS(NU), .PHYS_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending result per unit, last-served pointer, and the
  // value the write port should show. Grant = first pending unit at or after
  // the pointer in circular order.
  bit              m_full [NU];
  logic [AW-1:0]   m_addr [NU];
  logic [DW-1:0]   m_data [NU];
  int              m_rr;
  logic            m_commit;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata;
  longint          m_stall;
  int              m_win;
  logic [NU-1:0]   m_er;
  bit              acc [NU];
  logic [NU-1:0]   s_valid;
  logic [NU-1:0][AW-1:0] s_addr;
  logic [NU-1:0][DW-1:0] s_data;

  task automatic model_clear();
    for (int i = 0; i < NU; i++) begin
      m_full[i] = 0; m_addr[i] = '0; m_data[i] = '0; acc[i] = 0;
    end
    m_rr = 0; m_commit = 0; m_waddr = '0; m_wdata = '0; m_stall = 0;
  endtask

  // Sample at the falling edge and compare against the model.
  task automatic at_neg();
    @(negedge clk);
    m_win = -1;
    for (int k = 0; k < NU; k++)
      if (m_win < 0 && m_full[(m_rr + k) % NU]) m_win = (m_rr + k) % NU;
    for (int i = 0; i < NU; i++) begin
      m_er[i] = !m_full[i] || (m_win == i);
      acc[i]  = bus.unit_valid[i] && m_er[i];
    end
    chk("ready", 64'(bus.unit_ready), 64'(m_er));
    chk("commit", 64'(bus.commit), 64'(m_commit));
    chk("write_addr", 64'(bus.write_addr), 64'(m_waddr));
    chk("new_data", 64'(bus.new_data), 64'(m_wdata));
`ifdef WB_STALL_CNT_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    s_valid = bus.unit_valid;
    s_addr  = bus.unit_addr;
    s_data  = bus.unit_data;
  endtask

  // Advance the model across the rising edge, return 1 time unit after it.
  task automatic adv();
    bit stalled;
    @(posedge clk);
    stalled = 0;
    for (int i = 0; i < NU; i++)
      if (m_full[i] && i != m_win) stalled = 1;
    if (stalled && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (m_win >= 0) begin
      m_commit = (m_addr[m_win] != 0);
      m_waddr  = m_addr[m_win];
      m_wdata  = m_data[m_win];
      m_rr     = (m_win + 1) % NU;
      m_full[m_win] = 0;
    end else begin
      m_commit = 0;
    end
    for (int i = 0; i < NU; i++)
      if (acc[i]) begin
        m_full[i] = 1; m_addr[i] = s_addr[i]; m_data[i] = s_data[i];
      end
    #1;
  endtask

  task automatic cyc();
    at_neg();
    adv();
  endtask

  task automatic do_reset();
    bus.unit_valid = 4'hF;
    rst_n = 1'b0;
    #3;
    chk("rst_commit", 64'(bus.commit), 64'd0);
    chk("rst_write_addr", 64'(bus.write_addr), 64'd0);
    chk("rst_new_data", 64'(bus.new_data), 64'd0);
    chk("rst_ready", 64'(bus.unit_ready), 64'hF);
    model_clear();
    @(negedge clk);
    bus.unit_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NU-1:0] valid;
    int            unit;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ecommit;
    logic [AW-1:0] ewaddr;
    logic [DW-1:0] ewdata;
    logic [NU-1:0] eready;
  } vec_t;

  function automatic vec_t mk(logic [NU-1:0] v, int u, logic [AW-1:0] a, logic [DW-1:0] d,
                              logic ec, logic [AW-1:0] ea, logic [DW-1:0] ed, logic [NU-1:0] er);
    vec_t r;
    r.valid = v; r.unit = u; r.addr = a; r.data = d;
    r.ecommit = ec; r.ewaddr = ea; r.ewdata = ed; r.eready = er;
    return r;
  endfunction

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.unit_valid = '0;
    bus.unit_addr  = '0;
    bus.unit_data  = '0;
    model_clear();

    // single result, then address-0 drop followed by a real result from the same unit
    tbl[0] = mk(4'b0010, 1, 6'd5, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'h0,         4'hF);
    tbl[1] = mk(4'b0000, 1, 6'd5, 32'hDEAD_BEEF, 1'b0, 6'd0, 32'h0,         4'hF);
    tbl[2] = mk(4'b0000, 1, 6'd5, 32'hDEAD_BEEF, 1'b1, 6'd5, 32'hDEAD_BEEF, 4'hF);
    tbl[3] = mk(4'b0000, 1, 6'd5, 32'hDEAD_BEEF, 1'b0, 6'd5, 32'hDEAD_BEEF, 4'hF);
    tbl[4] = mk(4'b0100, 2, 6'd0, 32'h1234,      1'b0, 6'd5, 32'hDEAD_BEEF, 4'hF);
    tbl[5] = mk(4'b0100, 2, 6'd7, 32'h77,        1'b0, 6'd5, 32'hDEAD_BEEF, 4'hF);
    tbl[6] = mk(4'b0000, 2, 6'd7, 32'h77,        1'b0, 6'd0, 32'h1234,      4'hF);
    tbl[7] = mk(4'b0000, 2, 6'd7, 32'h77,        1'b1, 6'd7, 32'h77,        4'hF);
    tbl[8] = mk(4'b0000, 2, 6'd7, 32'h77,        1'b0, 6'd7, 32'h77,        4'hF);

    #2;
    do_reset();
    for (int r = 0; r < 9; r++) begin
      bus.unit_valid = tbl[r].valid;
      bus.unit_addr[tbl[r].unit] = tbl[r].addr;
      bus.unit_data[tbl[r].unit] = tbl[r].data;
      at_neg();
      chk($sformatf("tbl%0d_commit", r), 64'(bus.commit), 64'(tbl[r].ecommit));
      chk($sformatf("tbl%0d_addr", r), 64'(bus.write_addr), 64'(tbl[r].ewaddr));
      chk($sformatf("tbl%0d_data", r), 64'(bus.new_data), 64'(tbl[r].ewdata));
      chk($sformatf("tbl%0d_ready", r), 64'(bus.unit_ready), 64'(tbl[r].eready));
      adv();
    end

    // contention: every unit always offers, commits rotate 0,1,2,3,...
    do_reset();
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < NU; i++)
        if (c == 0 || acc[i]) begin
          bus.unit_addr[i] = {4'(c + 1), 2'(i)};
          bus.unit_data[i] = 32'(c * 256 + i);
        end
      bus.unit_valid = 4'hF;
      at_neg();
      if (c >= 2) begin
        chk("rot_commit", 64'(bus.commit), 64'd1);
        chk("rot_unit", 64'(bus.write_addr[1:0]), 64'((c - 2) % NU));
      end
      if (c >= 1)
        chk("rot_ready", 64'(bus.unit_ready), 64'(4'b0001 << ((c - 1) % NU)));
      adv();
    end

    // back-to-back from a single unit: no bubbles
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.unit_valid   = (c < 8) ? 4'b0001 : 4'b0000;
      bus.unit_addr[0] = 6'(c + 1);
      bus.unit_data[0] = 32'hA000_0000 + 32'(c);
      at_neg();
      if (c < 8) chk("b2b_ready", 64'(bus.unit_ready[0]), 64'd1);
      if (c >= 2) begin
        chk("b2b_commit", 64'(bus.commit), 64'd1);
        chk("b2b_addr", 64'(bus.write_addr), 64'(c - 1));
      end
      adv();
    end

    // reset mid-burst with three buffers full and a commit in flight
    do_reset();
    for (int i = 0; i < NU; i++) begin
      bus.unit_addr[i] = 6'(20 + i);
      bus.unit_data[i] = 32'hC0DE_0000 + 32'(i);
    end
    bus.unit_valid = 4'b0111;
    cyc();
    cyc();
    bus.unit_valid = '0;
    #1;
    chk("pre_rst_commit", 64'(bus.commit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_commit", 64'(bus.commit), 64'd0);
    chk("midrst_addr", 64'(bus.write_addr), 64'd0);
    chk("midrst_ready", 64'(bus.unit_ready), 64'hF);
`ifdef WB_STALL_CNT_EN
    chk("midrst_stall", 64'(stall_cycles), 64'd0);
`endif
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      at_neg();
      chk("post_rst_commit", 64'(bus.commit), 64'd0);
      adv();
    end

    // randomized traffic against the model; offers are held until accepted
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NU; i++)
        if (!bus.unit_valid[i] || acc[i]) begin
          bus.unit_valid[i] = ($urandom % 4) != 0;
          bus.unit_addr[i]  = (($urandom % 8) == 0) ? 6'd0 : 6'($urandom);
          bus.unit_data[i]  = $urandom;
        end
      cyc();
    end
    bus.unit_valid = '0;
    for (int c = 0; c < 6; c++) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
